// File: rtl/sfr_multi_pkg.sv
// Shared constants and helpers for the SFR block: address map, pending-bit
// layout and the byte-lane write merge used by every writable register.
package sfr_pkg;

  localparam logic [7:0] A_LED7      = 8'h00;
  localparam logic [7:0] A_PEND      = 8'h02;
  localparam logic [7:0] A_MASK      = 8'h04;
  localparam logic [7:0] A_TIMH      = 8'h08;
  localparam logic [7:0] A_TIML      = 8'h0A;
  localparam logic [7:0] A_CMP_BASE  = 8'h10;
  localparam logic [7:0] A_GPIO_BASE = 8'h20;

  localparam int CMP_STRIDE  = 4;
  localparam int GPIO_STRIDE = 8;

  localparam int PEND_TMR  = 0;
  localparam int PEND_GPIO = 8;

  // register select inside one GPIO port window (addr[2:1])
  typedef enum logic [1:0] {
    G_OUT = 2'd0,
    G_OE  = 2'd1,
    G_IN  = 2'd2,
    G_IEN = 2'd3
  } gpio_reg_e;

  // word compare: bus bit 0 is a byte offset and never selects a register
  function automatic logic word_hit(input logic [7:0] addr, input logic [7:0] a);
    return addr[7:1] == a[7:1];
  endfunction

  // address of compare channel k, high half (lo=0) or low half (lo=1)
  function automatic logic [7:0] cmp_addr(input int k, input logic lo);
    return 8'(int'(A_CMP_BASE) + CMP_STRIDE * k + (lo ? 2 : 0));
  endfunction

  // apply the enabled byte lanes of d onto cur
  function automatic logic [15:0] byte_merge(input logic [15:0] cur,
                                             input logic [15:0] d,
                                             input logic [1:0]  w);
    return {w[1] ? d[15:8] : cur[15:8], w[0] ? d[7:0] : cur[7:0]};
  endfunction

endpackage

// File: rtl/sfr_multi_if.sv
// b16 SFR bus: CPU side is the master, the SFR block is the slave.
interface sfr_bus_if;
  logic        sel;
  logic [7:0]  addr;
  logic        r;
  logic [1:0]  w;
  logic [15:0] dwrite;
  logic [15:0] sfr_data;

  modport master (output sel, addr, r, w, dwrite, input sfr_data);
  modport slave  (input sel, addr, r, w, dwrite, output sfr_data);
endinterface

// File: rtl/sfr_multi_gpio_port.sv
// One GPIO port: OUT/OE/IEN registers, tristate pin drivers, a two-flop
// input synchroniser plus history flop, and the enabled-edge pulse.
module sfr_gpio_port
  import sfr_pkg::*;
#(
  parameter int GW = 16
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        hit,        // bus selected and addressing this port
  input  gpio_reg_e   rsel,
  input  logic [1:0]  w,
  input  logic [15:0] dwrite,
  output logic [15:0] rdata,
  output logic        edge_pulse,
  inout  wire  [GW-1:0] pins
);

  logic [GW-1:0] out_q, oe_q, ien_q;
  logic [GW-1:0] sync1, sync2, hist;
  logic [15:0]   merged;

  // register read word; bits above GW stay 0
  always_comb begin
    rdata = '0;
    case (rsel)
      G_OUT:   rdata = 16'(out_q);
      G_OE:    rdata = 16'(oe_q);
      G_IN:    rdata = 16'(sync2);
      G_IEN:   rdata = 16'(ien_q);
      default: rdata = '0;
    endcase
  end

  assign merged = byte_merge(rdata, dwrite, w);

  // byte-lane writes to the RW registers; IN is read-only
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      out_q <= '0;
      oe_q  <= '0;
      ien_q <= '0;
    end else if (hit && (w != 2'b00)) begin
      case (rsel)
        G_OUT:   out_q <= merged[GW-1:0];
        G_OE:    oe_q  <= merged[GW-1:0];
        G_IEN:   ien_q <= merged[GW-1:0];
        default: ;
      endcase
    end
  end

  // sync chain and history reset to the same value so no edge follows reset
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sync1 <= '0;
      sync2 <= '0;
      hist  <= '0;
    end else begin
      sync1 <= pins;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign edge_pulse = |((sync2 ^ hist) & ien_q);

  for (genvar i = 0; i < GW; i++) begin : g_pin
    assign pins[i] = oe_q[i] ? out_q[i] : 1'bz;
  end

endmodule

// File: rtl/sfr_multi.sv
// Special-function-register block on the b16 bus: LED7, free-running timer
// with tear-free reads, compare channels, GPIO ports and a pending/mask irq.
module sfr_multi
  import sfr_pkg::*;
#(
  parameter int NTIMER = 2,
  parameter int NGPIO  = 2,
  parameter int GW     = 16
) (
  input  logic              clk,
  input  logic              nreset,
  sfr_bus_if.slave          bus,
  output logic [15:0]       LED7,
  inout  wire  [NGPIO*GW-1:0] gpio,
  output logic              irq
);

  localparam logic [15:0] PEND_VALID =
    16'(((1 << NTIMER) - 1) << PEND_TMR) | 16'(((1 << NGPIO) - 1) << PEND_GPIO);

  logic        wr, rd;
  logic [15:0] wmask, rdata;
  logic [31:0] timer;
  logic [15:0] shadow, pend, mask, pend_set, pend_clr;

  logic [NTIMER-1:0][31:0] cmp;
  logic [NTIMER-1:0]       armed, cmp_hit;

  logic [NGPIO-1:0][15:0]  port_rd;
  logic [NGPIO-1:0]        port_hit, gpio_edge;

  assign wr    = bus.sel && (bus.w != 2'b00);
  assign rd    = bus.sel && bus.r;
  assign wmask = {{8{bus.w[1]}}, {8{bus.w[0]}}};

  // free-running timer; a TIMH read snapshots the low half for TIML
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      timer  <= '0;
      shadow <= '0;
    end else begin
      timer <= timer + 32'd1;
      if (rd && word_hit(bus.addr, A_TIMH)) shadow <= timer[15:0];
    end
  end

  // compare registers; a channel only fires once software has written it,
  // otherwise the reset value 0 would match the counter straight after reset
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cmp   <= '0;
      armed <= '0;
    end else if (wr) begin
      for (int k = 0; k < NTIMER; k++) begin
        if (word_hit(bus.addr, cmp_addr(k, 1'b0))) begin
          cmp[k][31:16] <= byte_merge(cmp[k][31:16], bus.dwrite, bus.w);
          armed[k]      <= 1'b1;
        end
        if (word_hit(bus.addr, cmp_addr(k, 1'b1))) begin
          cmp[k][15:0]  <= byte_merge(cmp[k][15:0], bus.dwrite, bus.w);
          armed[k]      <= 1'b1;
        end
      end
    end
  end

  for (genvar k = 0; k < NTIMER; k++) begin : g_cmp
    assign cmp_hit[k] = armed[k] && (timer == cmp[k]);
  end

  for (genvar p = 0; p < NGPIO; p++) begin : g_port
    localparam logic [7:0] BASE = 8'(int'(A_GPIO_BASE) + GPIO_STRIDE * p);
    assign port_hit[p] = bus.sel && (bus.addr[7:3] == BASE[7:3]);

    sfr_gpio_port #(.GW(GW)) u_port (
      .clk        (clk),
      .nreset     (nreset),
      .hit        (port_hit[p]),
      .rsel       (gpio_reg_e'(bus.addr[2:1])),
      .w          (bus.w),
      .dwrite     (bus.dwrite),
      .rdata      (port_rd[p]),
      .edge_pulse (gpio_edge[p]),
      .pins       (gpio[p*GW +: GW])
    );
  end

  // pending-bit sources and the W1C clear mask (enabled byte lanes only)
  always_comb begin
    pend_set = '0;
    pend_set[PEND_TMR  +: NTIMER] = cmp_hit;
    pend_set[PEND_GPIO +: NGPIO]  = gpio_edge;
    pend_clr = '0;
    if (wr && word_hit(bus.addr, A_PEND)) pend_clr = bus.dwrite & wmask;
  end

  // LED7, MASK, PEND (set beats clear) and the registered irq
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      LED7 <= '0;
      mask <= '0;
      pend <= '0;
      irq  <= 1'b0;
    end else begin
      if (wr && word_hit(bus.addr, A_LED7)) LED7 <= byte_merge(LED7, bus.dwrite, bus.w);
      if (wr && word_hit(bus.addr, A_MASK)) mask <= byte_merge(mask, bus.dwrite, bus.w);
      pend <= ((pend & ~pend_clr) | pend_set) & PEND_VALID;
      irq  <= |(pend & mask);
    end
  end

  // combinational read mux; idle bus and unmapped addresses return 0
  always_comb begin
    rdata = '0;
    if (rd) begin
      if (word_hit(bus.addr, A_LED7)) rdata = LED7;
      if (word_hit(bus.addr, A_PEND)) rdata = pend;
      if (word_hit(bus.addr, A_MASK)) rdata = mask;
      if (word_hit(bus.addr, A_TIMH)) rdata = timer[31:16];
      if (word_hit(bus.addr, A_TIML)) rdata = shadow;
      for (int k = 0; k < NTIMER; k++) begin
        if (word_hit(bus.addr, cmp_addr(k, 1'b0))) rdata = cmp[k][31:16];
        if (word_hit(bus.addr, cmp_addr(k, 1'b1))) rdata = cmp[k][15:0];
      end
      for (int p = 0; p < NGPIO; p++) begin
        if (port_hit[p]) rdata = port_rd[p];
      end
    end
  end

  assign bus.sfr_data = rdata;

endmodule

// File: tb/tb_sfr_multi.sv
// Scoreboarded bench for sfr_multi: directed scenarios plus random bus
// traffic, checked against a cycle-level register model of the block.
module tb_sfr_multi;
  localparam int NTIMER = 2;
  localparam int NGPIO  = 2;
  localparam int GW     = 16;
  localparam int NP     = NGPIO * GW;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  always #5 clk = ~clk;

  sfr_bus_if bus();
  logic [15:0] LED7;
  logic        irq;
  wire  [NP-1:0] gpio;
  logic [NP-1:0] ext_val = '0;
  logic [NP-1:0] ext_en  = '1;

  for (genvar i = 0; i < NP; i++) begin : g_ext
    assign gpio[i] = ext_en[i] ? ext_val[i] : 1'bz;
  end

  sfr_multi #(.NTIMER(NTIMER), .NGPIO(NGPIO), .GW(GW)) dut (
    .clk(clk), .nreset(nreset), .bus(bus), .LED7(LED7), .gpio(gpio), .irq(irq)
  );

  int n_chk = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  // ---------------- reference model ----------------
  logic [31:0] m_timer;
  logic [15:0] m_shadow, m_led, m_pend, m_mask;
  logic        m_irq;
  logic [31:0] m_cmp   [NTIMER];
  logic        m_armed [NTIMER];
  logic [GW-1:0] m_out [NGPIO];
  logic [GW-1:0] m_oe  [NGPIO];
  logic [GW-1:0] m_ien [NGPIO];
  logic [NP-1:0] m_smp [3];   // pin samples: [0] newest, [1] visible as IN, [2] oldest

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_timer = 0; m_shadow = 0; m_led = 0; m_pend = 0; m_mask = 0; m_irq = 0;
    for (int k = 0; k < NTIMER; k++) begin m_cmp[k] = 0; m_armed[k] = 0; end
    for (int p = 0; p < NGPIO; p++) begin m_out[p] = 0; m_oe[p] = 0; m_ien[p] = 0; end
    for (int s = 0; s < 3; s++) m_smp[s] = '0;
  endfunction

  function automatic logic [NP-1:0] flat_oe();
    logic [NP-1:0] f;
    for (int p = 0; p < NGPIO; p++) f[p*GW +: GW] = m_oe[p];
    return f;
  endfunction

  function automatic logic [NP-1:0] pins_now();
    logic [NP-1:0] f;
    for (int p = 0; p < NGPIO; p++)
      f[p*GW +: GW] = (m_oe[p] & m_out[p]) | (~m_oe[p] & ext_val[p*GW +: GW]);
    return f;
  endfunction

  function automatic logic [15:0] upd(input logic [15:0] old, input logic [15:0] be);
    return (old & ~be) | (bus.dwrite & be);
  endfunction

  function automatic logic [15:0] model_read(input logic [7:0] a8);
    int a = int'({a8[7:1], 1'b0});
    int p;
    logic [15:0] v = '0;
    if (a == 0) v = m_led;
    else if (a == 2) v = m_pend;
    else if (a == 4) v = m_mask;
    else if (a == 8) v = m_timer[31:16];
    else if (a == 10) v = m_shadow;
    else if (a >= 16 && a < 16 + 4 * NTIMER)
      v = (a % 4 == 0) ? m_cmp[(a - 16) / 4][31:16] : m_cmp[(a - 16) / 4][15:0];
    else if (a >= 32 && a < 32 + 8 * NGPIO) begin
      p = (a - 32) / 8;
      case ((a % 8) / 2)
        0: v = 16'(m_out[p]);
        1: v = 16'(m_oe[p]);
        2: v = 16'(m_smp[1][p*GW +: GW]);
        default: v = 16'(m_ien[p]);
      endcase
    end
    return v;
  endfunction

  // one clock edge of the block, given the bus op presented this cycle
  function automatic void model_step();
    int a = int'({bus.addr[7:1], 1'b0});
    int k, p;
    logic [15:0] be = {{8{bus.w[1]}}, {8{bus.w[0]}}};
    logic [15:0] set = '0, clr = '0;
    logic [15:0] valid = 16'(((1 << NTIMER) - 1) | (((1 << NGPIO) - 1) << 8));
    for (int c = 0; c < NTIMER; c++) if (m_armed[c] && m_cmp[c] == m_timer) set[c] = 1'b1;
    for (int g = 0; g < NGPIO; g++)
      if (((m_smp[1][g*GW +: GW] ^ m_smp[2][g*GW +: GW]) & m_ien[g]) != 0) set[8 + g] = 1'b1;
    m_irq = |(m_pend & m_mask);
    m_smp[2] = m_smp[1];
    m_smp[1] = m_smp[0];
    m_smp[0] = pins_now();
    if (bus.sel && bus.r && a == 8) m_shadow = m_timer[15:0];
    if (bus.sel && bus.w != 2'b00) begin
      if (a == 0) m_led = upd(m_led, be);
      else if (a == 2) clr = bus.dwrite & be;
      else if (a == 4) m_mask = upd(m_mask, be);
      else if (a >= 16 && a < 16 + 4 * NTIMER) begin
        k = (a - 16) / 4;
        if (a % 4 == 0) m_cmp[k][31:16] = upd(m_cmp[k][31:16], be);
        else            m_cmp[k][15:0]  = upd(m_cmp[k][15:0], be);
        m_armed[k] = 1'b1;
      end else if (a >= 32 && a < 32 + 8 * NGPIO) begin
        p = (a - 32) / 8;
        case ((a % 8) / 2)
          0: m_out[p] = GW'(upd(16'(m_out[p]), be));
          1: m_oe[p]  = GW'(upd(16'(m_oe[p]), be));
          3: m_ien[p] = GW'(upd(16'(m_ien[p]), be));
          default: ;
        endcase
      end
    end
    m_pend = ((m_pend & ~clr) | set) & valid;
    m_timer = m_timer + 1;
  endfunction

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    if (nreset) model_step();
    #1;
    bus.sel = 0; bus.r = 0; bus.w = 0; bus.addr = 0; bus.dwrite = 0;
    ext_en = ~flat_oe();
  endtask

  task automatic bus_op(input logic s, input logic [7:0] a, input logic rd,
                        input logic [1:0] w, input logic [15:0] d);
    bus.sel = s; bus.addr = a; bus.r = rd; bus.w = w; bus.dwrite = d;
    if (s && rd) exp_q.push_back(model_read(a));
    tick();
  endtask

  task automatic rd_op(input logic [7:0] a);
    bus_op(1'b1, a, 1'b1, 2'b00, 16'h0);
  endtask

  task automatic wr_op(input logic [7:0] a, input logic [1:0] w, input logic [15:0] d);
    bus_op(1'b1, a, 1'b0, w, d);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [15:0] e;
    if (bus.sel && bus.r) begin
      if (exp_q.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL rd_unexpected: addr %h got %h with no expectation", bus.addr, bus.sfr_data);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("rd[%h]", bus.addr), 32'(bus.sfr_data), 32'(e));
      end
    end else begin
      chk("rd_idle", 32'(bus.sfr_data), 32'h0);
    end
    chk("irq", 32'(irq), 32'(m_irq));
    chk("led7", 32'(LED7), 32'(m_led));
    chk("gpio", 32'(gpio), 32'(pins_now()));
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  logic [7:0] alist[$];
  logic [31:0] target;

  task automatic read_all();
    rd_op(8'h0A);
    for (int i = 0; i < alist.size(); i++) rd_op(alist[i]);
  endtask

  task automatic random_ops(input int n);
    logic [7:0] a;
    for (int i = 0; i < n; i++) begin
      a = alist[$urandom_range(alist.size() - 1)] | 8'($urandom_range(1));
      if ($urandom_range(7) == 0) ext_val = NP'($urandom);
      bus_op($urandom_range(4) != 0, a, 1'($urandom), 2'($urandom), 16'($urandom));
    end
  endtask

  initial begin
    bus.sel = 0; bus.r = 0; bus.w = 0; bus.addr = 0; bus.dwrite = 0;
    model_reset();
    alist = {8'h00, 8'h02, 8'h04, 8'h08, 8'h0A, 8'h06, 8'h0C, 8'h0E, 8'h40, 8'hFE};
    for (int k = 0; k < NTIMER; k++) begin
      alist.push_back(8'(16 + 4 * k)); alist.push_back(8'(18 + 4 * k));
    end
    alist.push_back(8'(16 + 4 * NTIMER));
    for (int p = 0; p < NGPIO; p++)
      for (int r = 0; r < 4; r++) alist.push_back(8'(32 + 8 * p + 2 * r));

    // reset and post-reset reads
    repeat (3) tick();
    nreset = 1;
    read_all();

    // byte-lane writes to LED7, including an odd-address alias
    wr_op(8'h00, 2'b10, 16'hABCD);
    wr_op(8'h00, 2'b01, 16'h1234);
    rd_op(8'h00);
    rd_op(8'h01);

    // compare channel 0 at 0x40 with irq enabled, then W1C
    wr_op(8'h10, 2'b11, 16'h0000);
    wr_op(8'h12, 2'b11, 16'h0040);
    wr_op(8'h04, 2'b11, 16'h0001);
    for (int g = 0; g < 200 && m_timer < 32'h48; g++) rd_op(8'h02);
    wr_op(8'h02, 2'b11, 16'h0001);
    rd_op(8'h02);
    tick(); tick();

    // tear-free timer read
    rd_op(8'h08);
    repeat (5) tick();
    rd_op(8'h0A);

    // GPIO port 1: low byte driven, bit 15 driven externally with IEN
    ext_val = '0;
    wr_op(8'h28, 2'b11, 16'h005A);
    wr_op(8'h2A, 2'b11, 16'h00FF);
    wr_op(8'h2E, 2'b11, 16'h8000);
    wr_op(8'h04, 2'b11, 16'h0201);
    repeat (3) tick();
    ext_val[31:16] = 16'h8000;
    tick(); tick();
    rd_op(8'h2C);
    repeat (4) rd_op(8'h02);

    // set/clear collision on PEND[0]
    target = m_timer + 32'd20;
    wr_op(8'h10, 2'b11, target[31:16]);
    wr_op(8'h12, 2'b11, target[15:0]);
    for (int g = 0; g < 100 && m_timer != target; g++) tick();
    if (m_timer != target) begin
      n_chk++; n_err++;
      $display("FAIL collide_sync: timer %h never reached %h", m_timer, target);
    end
    wr_op(8'h02, 2'b11, 16'h0001);
    rd_op(8'h02);
    wr_op(8'h02, 2'b11, 16'h0001);
    rd_op(8'h02);

    // random traffic
    random_ops(400);

    // reset mid-operation
    #2;
    nreset = 0;
    model_reset();
    ext_en = '1;
    tick(); tick();
    nreset = 1;
    read_all();
    random_ops(150);

    tick();
    n_chk++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d reads left unchecked, required 0", exp_q.size());
    end
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
